pll_dri_ctrl: RTL

Runtime reconfiguration master for the PolarFire PLL Dynamic Reconfiguration Interface (DRI). The block drives the PLL's DRI port as initiator and accepts divider-change requests from fabric logic. For each request it performs a read-modify-write of one output-divider register, then waits for the PLL to report lock before signalling completion. It sits beside the PLL wrapper in the clocking subsystem and is clocked from a free-running reference clock, not from a PLL output.

---
 rtl/pll_dri_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pll_dri_ctrl.sv
// PolarFire PLL DRI reconfiguration master: read-modify-write of one output divider, then wait for lock.
// Optional build macro PLL_DRI_TIMEOUT_EN adds ack and lock timeouts that abort with err=1.
module pll_dri_ctrl #(
    parameter logic [8:0]  DIV_ADDR_BASE = 9'h010,
    parameter int unsigned DIV_LSB       = 8,
    parameter int unsigned SETTLE_CYC    = 16,
    parameter int unsigned ACK_TIMEOUT   = 64,
    parameter int unsigned LOCK_TIMEOUT  = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_out,
    input  logic [6:0]  req_div,
    output logic        done,
    output logic        err,
    output logic [10:0] dri_ctrl,
    output logic [32:0] dri_wdata,
    input  logic [32:0] dri_rdata,
    output logic        dri_arst_n,
    input  logic        lock
);

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, SETTLE, WAIT_LOCK, DONE} state_t;

    localparam int unsigned SC_W = $clog2(SETTLE_CYC) + 1;

`ifdef PLL_DRI_TIMEOUT_EN
    localparam int unsigned TMO_MAX = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned TMO_W   = $clog2(TMO_MAX) + 1;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
`endif

    state_t            state, state_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [6:0]        div, div_nxt;
    logic [31:0]       data, data_nxt;
    logic              fail, fail_nxt;
    logic [SC_W-1:0]   settle_cnt, settle_nxt;
    logic              ack;
    logic [8:0]        addr_nxt;
    logic [10:0]       ctrl_nxt;
    logic [32:0]       wdata_nxt;

    // An ack only counts while our own strobe is up.
    assign ack = dri_rdata[32] & dri_ctrl[10];

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        div_nxt    = div;
        data_nxt   = data;
        fail_nxt   = fail;
        settle_nxt = settle_cnt;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    idx_nxt   = req_out;
                    div_nxt   = req_div;
                    fail_nxt  = (req_div == '0);
                    state_nxt = (req_div == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                if (ack) begin
                    data_nxt                = dri_rdata[31:0];
                    data_nxt[DIV_LSB +: 7]  = div;
                    state_nxt               = WR_REQ;
                end
`ifdef PLL_DRI_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    fail_nxt  = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            WR_REQ: begin
                if (ack) begin
                    settle_nxt = '0;
                    state_nxt  = SETTLE;
                end
`ifdef PLL_DRI_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    fail_nxt  = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            SETTLE: begin
                if (settle_cnt == SC_W'(SETTLE_CYC - 1)) begin
                    settle_nxt = '0;
                    state_nxt  = WAIT_LOCK;
                end else begin
                    settle_nxt = settle_cnt + SC_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock) begin
                    fail_nxt  = 1'b0;
                    state_nxt = DONE;
                end
`ifdef PLL_DRI_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    fail_nxt  = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

`ifdef PLL_DRI_TIMEOUT_EN
        tmo_nxt = (state_nxt != state || state == IDLE) ? '0 : tmo_cnt + TMO_W'(1);
`endif

        // Outputs are registered from the next state so strobes appear the cycle after a transition.
        addr_nxt  = DIV_ADDR_BASE + {7'd0, idx_nxt};
        ctrl_nxt  = '0;
        wdata_nxt = '0;
        case (state_nxt)
            RD_REQ: ctrl_nxt = {2'b10, addr_nxt};
            WR_REQ: begin
                ctrl_nxt  = {2'b11, addr_nxt};
                wdata_nxt = {1'b1, data_nxt};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        dri_arst_n <= reset_n;
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            div        <= '0;
            data       <= '0;
            fail       <= 1'b0;
            settle_cnt <= '0;
`ifdef PLL_DRI_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
            req_ready  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            dri_ctrl   <= '0;
            dri_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            div        <= div_nxt;
            data       <= data_nxt;
            fail       <= fail_nxt;
            settle_cnt <= settle_nxt;
`ifdef PLL_DRI_TIMEOUT_EN
            tmo_cnt    <= tmo_nxt;
`endif
            req_ready  <= (state_nxt == IDLE);
            done       <= (state_nxt == DONE);
            err        <= (state_nxt == DONE) && fail_nxt;
            dri_ctrl   <= ctrl_nxt;
            dri_wdata  <= wdata_nxt;
        end
    end

endmodule
